// File: rtl/pam_frame_receiver.sv
// PAM serial frame receiver: oversamples nsync/bclk/sdata, captures one MSB-first word per frame, pushes it to a FIFO.
// Optional bclk-stall timeout is enabled by defining DESER_TIMEOUT_EN.
module pam_frame_receiver #(
    parameter int DATA_LENGTH  = 24,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   nsync,
    input  logic                   bclk,
    input  logic                   sdata,
    output logic [DATA_LENGTH-1:0] word,
    output logic                   write,
    input  logic                   full,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT_M1 = CNT_W'(DATA_LENGTH - 1);

    generate
        if (SYNC_STAGES < 2 || TIMEOUT_CLKS < 2) begin : g_bad_param
            $error("pam_frame_receiver: SYNC_STAGES and TIMEOUT_CLKS must both be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    // Line index 2 = nsync, 1 = bclk, 0 = sdata; all synchronizers idle high.
    logic [2:0] line_in;
    logic [2:0] line_sync;

    assign line_in = {nsync, bclk, sdata};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] stage_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_reg <= '1;
                end else begin
                    stage_reg <= {stage_reg[SYNC_STAGES-2:0], line_in[gi]};
                end
            end

            assign line_sync[gi] = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic nsync_s, bclk_s, sdata_s;
    logic nsync_d_reg, bclk_d_reg;
    logic nsync_fall, nsync_rise, bclk_fall;

    assign nsync_s = line_sync[2];
    assign bclk_s  = line_sync[1];
    assign sdata_s = line_sync[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nsync_d_reg <= 1'b1;
            bclk_d_reg  <= 1'b1;
        end else begin
            nsync_d_reg <= nsync_s;
            bclk_d_reg  <= bclk_s;
        end
    end

    assign nsync_fall = nsync_d_reg & ~nsync_s;
    assign nsync_rise = ~nsync_d_reg & nsync_s;
    assign bclk_fall  = bclk_d_reg & ~bclk_s;

    state_t                 state_reg, state_next;
    logic [DATA_LENGTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [DATA_LENGTH-1:0] word_reg, word_next;
    logic                   write_reg, write_next;
    logic                   err_reg, err_next;
    logic                   ovf_reg, ovf_next;

`ifdef DESER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            timeout_hit;

    // Counts clocks since the last bit; held at zero outside ST_SHIFT so entry starts fresh.
    always_comb begin
        to_cnt_next = '0;
        if (state_reg == ST_SHIFT && !bclk_fall && to_cnt_reg != TO_LAST) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ST_SHIFT) && !bclk_fall && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        write_next = 1'b0;
        err_next   = 1'b0;
        ovf_next   = ovf_reg & ~ovf_clr;

        case (state_reg)
            ST_IDLE: begin
                if (nsync_fall) begin
                    shift_next = '0;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cnt_reg == LAST_BIT) begin
                    // Completion has priority over a coincident nsync rise.
                    word_next = shift_reg;
                    if (full) begin
                        ovf_next = 1'b1;
                    end else begin
                        write_next = 1'b1;
                    end
                    err_next   = bclk_fall;
                    state_next = ST_WAIT_END;
                end else if (bclk_fall) begin
                    shift_next = {shift_reg[DATA_LENGTH-2:0], sdata_s};
                    cnt_next   = cnt_reg + 1'b1;
                    if (nsync_rise && cnt_reg != LAST_BIT_M1) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (nsync_rise) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
`ifdef DESER_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = ST_WAIT_END;
                end
`endif
            end

            ST_WAIT_END: begin
                err_next = bclk_fall;
                // Leaving on the synced level also covers a rise that landed on the completion clock.
                if (nsync_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            word_reg  <= '0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            write_reg <= write_next;
            err_reg   <= err_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign word      = word_reg;
    assign write     = write_reg;
    assign frame_err = err_reg;
    assign overflow  = ovf_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pam_frame_receiver.sv
// Scoreboard bench for pam_frame_receiver: directed frames at 12 clk per bclk, monitor checks writes and error pulses.
module tb_pam_frame_receiver;

    localparam int DL   = 24;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          nsync = 1'b1;
    logic          bclk = 1'b1;
    logic          sdata = 1'b0;
    logic          full = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DL-1:0] word;
    logic          write;
    logic          frame_err;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int exp_err_pending = 0;
    logic [DL-1:0] exp_word_q[$];

    pam_frame_receiver #(
        .DATA_LENGTH (DL),
        .SYNC_STAGES (2),
        .TIMEOUT_CLKS(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .nsync    (nsync),
        .bclk     (bclk),
        .sdata    (sdata),
        .word     (word),
        .write    (write),
        .full     (full),
        .frame_err(frame_err),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    // Drives nbits of data MSB first; bclk falls mid-bit, optionally raises nsync afterwards.
    task automatic send_bits(input logic [DL-1:0] data, input int nbits, input bit raise);
        @(negedge clk);
        nsync = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bclk  = 1'b1;
            sdata = data[DL-1-i];
            repeat (HALF) @(negedge clk);
            bclk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
        end
        if (raise) begin
            bclk  = 1'b1;
            nsync = 1'b1;
        end
    endtask

    // Monitor: pops the expected word on every write strobe and consumes expected error pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (write) begin
                check("write_expected", 32'(exp_word_q.size() != 0), 32'd1);
                if (exp_word_q.size() != 0) begin
                    logic [DL-1:0] exp_w;
                    exp_w = exp_word_q.pop_front();
                    check("write_word", 32'(word), 32'(exp_w));
                    check("write_latency", 32'(cyc - last_fall_cyc), 32'd4);
                end
            end
            if (frame_err) begin
                check("frame_err_expected", 32'(exp_err_pending > 0), 32'd1);
                if (exp_err_pending > 0) exp_err_pending--;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_word", 32'(word), 32'd0);
        check("reset_write", 32'(write), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame
        exp_word_q.push_back(24'hA5C3F0);
        send_bits(24'hA5C3F0, DL, 1'b1);
        repeat (10) @(negedge clk);
        check("t1_drained", 32'(exp_word_q.size()), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Two frames with a short nsync gap
        exp_word_q.push_back(24'h000001);
        exp_word_q.push_back(24'hFFFFFF);
        send_bits(24'h000001, DL, 1'b1);
        repeat (2) @(negedge clk);
        send_bits(24'hFFFFFF, DL, 1'b1);
        repeat (10) @(negedge clk);
        check("t2_drained", 32'(exp_word_q.size()), 32'd0);

        // Short frame: 10 bits then nsync rise
        exp_err_pending++;
        send_bits(24'hFFC000, 10, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_err_seen", 32'(exp_err_pending), 32'd0);
        check("t3_busy_idle", 32'(busy), 32'd0);
        exp_word_q.push_back(24'h123456);
        send_bits(24'h123456, DL, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_drained", 32'(exp_word_q.size()), 32'd0);

        // FIFO full: word updates, no write, sticky overflow
        full = 1'b1;
        send_bits(24'h654321, DL, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_word", 32'(word), 32'h654321);
        check("t4_overflow_set", 32'(overflow), 32'd1);
        full = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_overflow_held", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("t4_overflow_clr", 32'(overflow), 32'd0);

        // Reset in the middle of a frame
        send_bits(24'hDEAD00, 12, 1'b0);
        check("t5_busy_mid", 32'(busy), 32'd1);
        rst   = 1'b0;
        nsync = 1'b1;
        bclk  = 1'b1;
        @(negedge clk);
        check("t5_rst_word", 32'(word), 32'd0);
        check("t5_rst_write", 32'(write), 32'd0);
        check("t5_rst_frame_err", 32'(frame_err), 32'd0);
        check("t5_rst_overflow", 32'(overflow), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        exp_word_q.push_back(24'hABCDEF);
        send_bits(24'hABCDEF, DL, 1'b1);
        repeat (10) @(negedge clk);

        check("final_words_drained", 32'(exp_word_q.size()), 32'd0);
        check("final_errs_drained", 32'(exp_err_pending), 32'd0);
        check("final_overflow", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
